// File: rtl/event_encoder_8_to_3.sv
// Event encoder: captures events on eight lines into a pending set and presents
// them one at a time as a binary index using a valid/ready handshake.
//
// Parameters:
//   EDGE_MODE  1: capture rising edges of x; 0: capture the level of x every cycle
//   LSB_FIRST  0: highest pending index is presented first; 1: lowest first
// Ports:
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   enable    capture enable; only masks new captures
//   x[7:0]    event lines, x[i] = event i
//   clear     synchronous flush of pending events and overflow
//   y[2:0]    index of the presented event
//   valid     y holds a presented event
//   ready     consumer accepts y (handshake = valid && ready at a rising edge)
//   overflow  sticky: an event was captured while its bit was already pending
//   pend_cnt  popcount of the pending register
module event_encoder_8_to_3 #(
  parameter bit EDGE_MODE = 1'b1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] x,
  input  logic       clear,
  output logic [2:0] y,
  output logic       valid,
  input  logic       ready,
  output logic       overflow,
  output logic [3:0] pend_cnt
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e     state_q;
  logic [7:0] x_prev_q;
  logic [7:0] pending_q;
  logic [2:0] y_q;
  logic       overflow_q;

  logic       handshake;
  logic [7:0] cap;
  logic [7:0] served;
  logic [7:0] pend_d;
  logic       ovf_hit;
  logic [2:0] prio_idx;
  logic [3:0] cnt;

  function automatic logic [2:0] prio(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST) begin
      // Scan downward so the lowest set bit is the last one written.
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    handshake = (state_q == StPresent) && ready;
    cap       = (EDGE_MODE ? (x & ~x_prev_q) : x) & {8{enable}};
    served    = handshake ? (8'b1 << y_q) : 8'b0;
    // A bit served and re-captured in the same cycle stays set without overflow.
    pend_d    = (pending_q & ~served) | cap;
    ovf_hit   = |(cap & pending_q & ~served);
    prio_idx  = prio(pend_d);
  end

  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, pending_q[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_prev_q   <= 8'h00;
      pending_q  <= 8'h00;
      y_q        <= 3'd0;
      state_q    <= StIdle;
      overflow_q <= 1'b0;
    end else begin
      x_prev_q <= x;
      if (clear) begin
        // Captures and handshakes in this cycle are dropped.
        pending_q  <= 8'h00;
        y_q        <= 3'd0;
        state_q    <= StIdle;
        overflow_q <= 1'b0;
      end else begin
        pending_q <= pend_d;
        if (ovf_hit) overflow_q <= 1'b1;
        unique case (state_q)
          StIdle: begin
            if (|pend_d) begin
              state_q <= StPresent;
              y_q     <= prio_idx;
            end else begin
              y_q <= 3'd0;
            end
          end
          StPresent: begin
            // Without a handshake the presented index holds, even if a
            // higher-priority event arrives.
            if (handshake) begin
              if (|pend_d) begin
                y_q <= prio_idx;
              end else begin
                state_q <= StIdle;
                y_q     <= 3'd0;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            y_q     <= 3'd0;
          end
        endcase
      end
    end
  end

  assign y        = y_q;
  assign valid    = (state_q == StPresent);
  assign overflow = overflow_q;
  assign pend_cnt = cnt;

endmodule

// File: tb/tb_event_encoder_8_to_3.sv
// Self-checking bench for event_encoder_8_to_3: a table of per-cycle vectors
// for the default configuration, plus hand sequences for asynchronous reset and
// a level-mode, lowest-first instance.
module tb_event_encoder_8_to_3;

  logic       clk;
  logic       rst;

  logic       enable, clear, ready;
  logic [7:0] x;
  logic [2:0] y;
  logic       valid, overflow;
  logic [3:0] pend_cnt;

  logic       enable2, clear2, ready2;
  logic [7:0] x2;
  logic [2:0] y2;
  logic       valid2, overflow2;
  logic [3:0] pend_cnt2;

  int n_pass;
  int n_total;

  event_encoder_8_to_3 u_dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .x        (x),
    .clear    (clear),
    .y        (y),
    .valid    (valid),
    .ready    (ready),
    .overflow (overflow),
    .pend_cnt (pend_cnt)
  );

  event_encoder_8_to_3 #(
    .EDGE_MODE (1'b0),
    .LSB_FIRST (1'b1)
  ) u_dut_lvl (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable2),
    .x        (x2),
    .clear    (clear2),
    .y        (y2),
    .valid    (valid2),
    .ready    (ready2),
    .overflow (overflow2),
    .pend_cnt (pend_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic       en;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [2:0] ey;
    logic [3:0] ec;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] vx, input logic ven, input logic vrdy,
                              input logic vclr, input logic vev, input logic [2:0] vey,
                              input logic [3:0] vec, input logic veo);
    vec_t v;
    v.x = vx; v.en = ven; v.rdy = vrdy; v.clr = vclr;
    v.ev = vev; v.ey = vey; v.ec = vec; v.eo = veo;
    return v;
  endfunction

  // Compares {valid, y, pend_cnt, overflow}.
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got v=%b y=%0d cnt=%0d ovf=%b, expected v=%b y=%0d cnt=%0d ovf=%b",
               name, act[8], act[7:5], act[4:1], act[0], exp[8], exp[7:5], exp[4:1], exp[0]);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    x       = 8'hFF;
    enable  = 1'b1;
    ready   = 1'b1;
    clear   = 1'b0;
    x2      = 8'h00;
    enable2 = 1'b0;
    ready2  = 1'b0;
    clear2  = 1'b0;

    // Drain all eight from reset, highest first (x high at release counts as edges).
    vecs.push_back(mk(8'hFF, 1, 1, 0, 1, 3'd7, 4'd8, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 1, 3'd6, 4'd7, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 1, 3'd5, 4'd6, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 1, 3'd4, 4'd5, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 1, 3'd3, 4'd4, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 1, 3'd2, 4'd3, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 1, 3'd1, 4'd2, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 1, 3'd0, 4'd1, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 0, 3'd0, 4'd0, 0));
    vecs.push_back(mk(8'h00, 1, 1, 0, 0, 3'd0, 4'd0, 0));
    // y=2 held while higher-priority 5 arrives; one handshake then moves to 5.
    vecs.push_back(mk(8'h04, 1, 0, 0, 1, 3'd2, 4'd1, 0));
    vecs.push_back(mk(8'h24, 1, 0, 0, 1, 3'd2, 4'd2, 0));
    vecs.push_back(mk(8'h24, 1, 1, 0, 1, 3'd5, 4'd1, 0));
    vecs.push_back(mk(8'h24, 1, 1, 0, 0, 3'd0, 4'd0, 0));
    // Bit 3 re-captured while pending: overflow; clear flushes it.
    vecs.push_back(mk(8'h08, 1, 0, 0, 1, 3'd3, 4'd1, 0));
    vecs.push_back(mk(8'h00, 1, 0, 0, 1, 3'd3, 4'd1, 0));
    vecs.push_back(mk(8'h08, 1, 0, 0, 1, 3'd3, 4'd1, 1));
    vecs.push_back(mk(8'h08, 1, 0, 1, 0, 3'd0, 4'd0, 0));
    vecs.push_back(mk(8'h00, 1, 1, 0, 0, 3'd0, 4'd0, 0));
    // Bit 4 served and re-captured in one cycle: stays presented, no overflow.
    vecs.push_back(mk(8'h10, 1, 0, 0, 1, 3'd4, 4'd1, 0));
    vecs.push_back(mk(8'h00, 1, 0, 0, 1, 3'd4, 4'd1, 0));
    vecs.push_back(mk(8'h10, 1, 1, 0, 1, 3'd4, 4'd1, 0));
    vecs.push_back(mk(8'h10, 1, 1, 0, 0, 3'd0, 4'd0, 0));
    // Pending 0A drains with enable low; toggling x captures nothing.
    vecs.push_back(mk(8'h0A, 1, 0, 0, 1, 3'd3, 4'd2, 0));
    vecs.push_back(mk(8'hF5, 0, 1, 0, 1, 3'd1, 4'd1, 0));
    vecs.push_back(mk(8'h0A, 0, 1, 0, 0, 3'd0, 4'd0, 0));
    vecs.push_back(mk(8'hF5, 0, 1, 0, 0, 3'd0, 4'd0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 0, 0, 3'd0, 4'd0, 0));
    // Captures in a clear cycle are dropped; x_prev still follows x.
    vecs.push_back(mk(8'hFF, 1, 1, 1, 0, 3'd0, 4'd0, 0));
    vecs.push_back(mk(8'hFF, 1, 1, 0, 0, 3'd0, 4'd0, 0));

    // Reset state, sampled while rst is high and across an edge.
    #2;
    check("reset_state", {valid, y, pend_cnt, overflow}, 9'b0);
    step();
    check("reset_held", {valid, y, pend_cnt, overflow}, 9'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      x      = vecs[i].x;
      enable = vecs[i].en;
      ready  = vecs[i].rdy;
      clear  = vecs[i].clr;
      step();
      check($sformatf("vec%0d", i), {valid, y, pend_cnt, overflow},
            {vecs[i].ev, vecs[i].ey, vecs[i].ec, vecs[i].eo});
    end

    // Asynchronous reset mid-presentation drops everything before any edge.
    enable = 1'b1; ready = 1'b0; clear = 1'b0;
    x = 8'h00;
    step();
    x = 8'h03;
    step();
    check("pre_async_rst", {valid, y, pend_cnt, overflow}, {1'b1, 3'd1, 4'd2, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {valid, y, pend_cnt, overflow}, 9'b0);
    step();
    rst = 1'b0;
    // x still high at release is seen as rising edges.
    step();
    check("edge_at_release", {valid, y, pend_cnt, overflow}, {1'b1, 3'd1, 4'd2, 1'b0});
    ready = 1'b1;
    step();
    check("release_drain1", {valid, y, pend_cnt, overflow}, {1'b1, 3'd0, 4'd1, 1'b0});
    step();
    check("release_drain2", {valid, y, pend_cnt, overflow}, 9'b0);

    // Level mode, lowest first, x=81 held: bit 0 is re-captured every cycle, so
    // lowest-first keeps selecting 0 with valid held high; bit 7 re-captured
    // while pending sets overflow.
    enable2 = 1'b1; ready2 = 1'b1; x2 = 8'h81;
    step();
    check("lvl_first", {valid2, y2, pend_cnt2, overflow2}, {1'b1, 3'd0, 4'd2, 1'b0});
    step();
    check("lvl_hold1", {valid2, y2, pend_cnt2, overflow2}, {1'b1, 3'd0, 4'd2, 1'b1});
    step();
    check("lvl_hold2", {valid2, y2, pend_cnt2, overflow2}, {1'b1, 3'd0, 4'd2, 1'b1});
    x2 = 8'h80;
    step();
    check("lvl_to7", {valid2, y2, pend_cnt2, overflow2}, {1'b1, 3'd7, 4'd1, 1'b1});
    x2 = 8'h00;
    step();
    check("lvl_idle", {valid2, y2, pend_cnt2, overflow2}, {1'b0, 3'd0, 4'd0, 1'b1});
    clear2 = 1'b1;
    step();
    check("lvl_clear", {valid2, y2, pend_cnt2, overflow2}, 9'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
